tx_arbiter: RTL and testbench
=============================

// Module: tx_arbiter
// PURPOSE
//  Round-robin scheduler that shares one mini-SPART transmitter (tx) among NUM_REQ byte sources.
//  Accepts bytes via per-requester valid/ready handshakes and drives tx en_tx/data.
//  Tracks tx busy through tbr and holds the transmitter for exactly one frame per grant.
//  A watchdog aborts a frame whose tbr never returns and raises a sticky error.
//  Sits between the bus-interface/requester logic and the tx instance, all on one clock.
// PARAMETERS
//  NUM_REQ    4       number of requesters (2..8)
//  IDX_W      2       grant index width, clog2(NUM_REQ)
//  TIMEOUT    16'hFFFF  max clk cycles in WAIT before abort (counter width 16)
//  PRIO0      0       1: requester 0 always wins when valid; 0: pure round-robin
// PORTS
//  clk         in   1            system clock
//  rst         in   1            asynchronous, active-high reset
//  arb_en      in   1            0: no new grants; frame in flight completes
//  req_valid   in   NUM_REQ      requester i has a byte
//  req_data    in   8*NUM_REQ    byte of requester i at [8*i+:8]
//  req_ready   out  NUM_REQ      one-hot accept pulse (combinational, IDLE only)
//  tx_en_tx    out  1            registered 1-cycle start strobe to tx.en_tx
//  tx_data     out  8            registered captured byte to tx.data
//  tx_tbr      in   1            tx.tbr; 1 = transmitter idle
//  grant_idx   out  IDX_W        index of last accepted requester
//  busy        out  1            1 while in START or WAIT
//  frame_done  out  1            1-cycle pulse when tbr returns high in WAIT
//  err_timeout out  1            sticky; set on watchdog abort, cleared only by rst
// BEHAVIOUR
//  Reset: state=IDLE, rr_ptr=0, req_ready=0, tx_en_tx=0, tx_data=8'h00, grant_idx=0,
//   busy=0, frame_done=0, err_timeout=0, wdog=0. Reset mid-frame aborts at once; tx shares rst.
//  States: IDLE -> START -> WAIT -> IDLE.
//  IDLE: if arb_en & tx_tbr & |req_valid: pick winner k (below). req_ready[k]=1 same cycle;
//   at clock edge tx_data<=req_data[k], grant_idx<=k, rr_ptr<=(k+1) mod NUM_REQ, ->START.
//   Otherwise req_ready=0 and stay.
//  START: tx_en_tx=1 exactly this cycle; wdog<=0; ->WAIT unconditionally.
//  WAIT: tx_en_tx=0; tx_tbr is ignored in the first WAIT cycle (tx enters TRANS there).
//   From the 2nd WAIT cycle on, tx_tbr=1 -> frame_done=1 and ->IDLE.
//   Otherwise wdog++ each cycle; wdog==TIMEOUT -> err_timeout<=1 and ->IDLE, no frame_done.
//  Arbitration: search i = rr_ptr, rr_ptr+1, ... wrapping at NUM_REQ; first valid wins.
//   PRIO0=1: req_valid[0] overrides the search; rr_ptr still updates to (k+1).
//  Latency: accept cycle N, en_tx at N+1, earliest frame_done N+3. Back-to-back: a new grant is
//   allowed in the same IDLE cycle that follows frame_done (tbr already 1).
//  tx_data holds its value from the accept edge until the next accept.
//  A requester dropping valid before ready loses nothing; no grant occurs without ready.
//  arb_en falling during START/WAIT does not abort the frame.
//  At most one req_ready bit is set in any cycle; all are 0 outside IDLE.
// STRUCTURE
//  spart_pkg: ARB_IDLE/ARB_START/ARB_WAIT state encodings (2 bits), TIMEOUT default, byte width 8.
//  Sub-module rr_pick: combinational (valid, ptr, prio0) -> (any, idx, onehot); reused by rx side.
//  tx_arbiter: FSM, rr_ptr, capture registers, watchdog counter.
// TESTING
//  1 single: req_valid=4'b0100, data[2]=8'hA5, tbr=1 -> ready=4'b0100 at N, en_tx=1 & tx_data=A5 at N+1.
//  2 fairness: all 4 valid continuously, rr_ptr=0 -> grants 0,1,2,3,0 in order, one per frame.
//  3 PRIO0=1: valid=4'b1001, rr_ptr=3 -> grant 0 first, rr_ptr becomes 1, then grant 3.
//  4 timeout: TIMEOUT=16'd20, hold tbr=0 after START -> abort after 20 WAIT cycles,
//    err_timeout=1, no frame_done.
//  5 reset mid-frame: assert rst in WAIT -> all outputs at reset values next cycle,
//    state IDLE, rr_ptr=0.
//  6 arb_en=0 with valid=4'b1111 -> no ready pulses; raise arb_en -> grant rr_ptr next cycle.

Source files
------------

// File: rtl/spart_pkg.sv
// spart_pkg: shared definitions for the mini-SPART transmit/receive arbitration logic.
//   BYTE_W       width of one SPART data byte
//   TIMEOUT_DEF  default watchdog limit in clk cycles (16-bit counter)
//   arb_state_e  arbiter FSM state encoding
package spart_pkg;

  localparam int unsigned BYTE_W      = 8;
  localparam logic [15:0] TIMEOUT_DEF = 16'hFFFF;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_START = 2'd1,
    ARB_WAIT  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin winner selection.
//   valid   in   NUM_REQ  request vector
//   ptr     in   IDX_W    first index to search from (wraps at NUM_REQ)
//   prio0   in   1        1: index 0 wins whenever valid[0] is set
//   any     out  1        at least one request is valid
//   idx     out  IDX_W    winning index (0 when any=0)
//   onehot  out  NUM_REQ  one-hot winner (all zero when any=0)
module rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IDX_W-1:0]   ptr,
  input  logic               prio0,
  output logic               any,
  output logic [IDX_W-1:0]   idx,
  output logic [NUM_REQ-1:0] onehot
);

  always_comb begin
    int cand;
    any    = |valid;
    idx    = '0;
    onehot = '0;
    cand   = 0;
    // Walk from the farthest offset back to ptr so the closest valid index is written last.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = int'(ptr) + i;
      if (cand >= int'(NUM_REQ)) begin
        cand = cand - int'(NUM_REQ);
      end
      if (valid[cand]) begin
        idx = IDX_W'(cand);
      end
    end
    if (prio0 && valid[0]) begin
      idx = '0;
    end
    if (any) begin
      onehot[idx] = 1'b1;
    end
  end

endmodule

// File: rtl/tx_arbiter.sv
// tx_arbiter: round-robin scheduler sharing one mini-SPART transmitter among NUM_REQ sources.
//   clk, rst     clock and asynchronous active-high reset
//   arb_en       0 blocks new grants; a frame already in flight completes
//   req_valid    per-requester byte-available flags
//   req_data     requester i byte at [8*i +: 8]
//   req_ready    one-hot accept pulse, combinational, only in IDLE
//   tx_en_tx     registered one-cycle start strobe to the transmitter
//   tx_data      byte captured at the accept edge, held until the next accept
//   tx_tbr       transmitter idle flag (1 = idle)
//   grant_idx    index of the last accepted requester
//   busy         high in START and WAIT
//   frame_done   one-cycle pulse when tbr returns in WAIT
//   err_timeout  sticky watchdog-abort flag, cleared only by rst
module tx_arbiter
  import spart_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = 2,
  parameter logic [15:0] TIMEOUT = TIMEOUT_DEF,
  parameter bit          PRIO0   = 1'b0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      arb_en,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [BYTE_W*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      tx_en_tx,
  output logic [BYTE_W-1:0]         tx_data,
  input  logic                      tx_tbr,
  output logic [IDX_W-1:0]          grant_idx,
  output logic                      busy,
  output logic                      frame_done,
  output logic                      err_timeout
);

  arb_state_e          state_q, state_d;
  logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [15:0]         wdog_q, wdog_d;
  logic [BYTE_W-1:0]   tx_data_q;
  logic [IDX_W-1:0]    grant_q;
  logic                en_q;
  logic                err_q;
  logic                capture;
  logic                abort;

  logic                pick_any;
  logic [IDX_W-1:0]    pick_idx;
  logic [NUM_REQ-1:0]  pick_onehot;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .valid  (req_valid),
    .ptr    (rr_ptr_q),
    .prio0  (PRIO0),
    .any    (pick_any),
    .idx    (pick_idx),
    .onehot (pick_onehot)
  );

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    wdog_d     = wdog_q;
    req_ready  = '0;
    frame_done = 1'b0;
    capture    = 1'b0;
    abort      = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        if (arb_en && tx_tbr && pick_any) begin
          req_ready = pick_onehot;
          capture   = 1'b1;
          rr_ptr_d  = (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
          state_d   = ARB_START;
        end
      end
      ARB_START: begin
        wdog_d  = '0;
        state_d = ARB_WAIT;
      end
      ARB_WAIT: begin
        // wdog_q is 0 only in the first WAIT cycle, where the transmitter has not
        // yet dropped tbr, so tbr is not trusted there.
        if ((wdog_q != '0) && tx_tbr) begin
          frame_done = 1'b1;
          state_d    = ARB_IDLE;
        end else begin
          wdog_d = wdog_q + 16'd1;
          if (wdog_d == TIMEOUT) begin
            abort   = 1'b1;
            state_d = ARB_IDLE;
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ARB_IDLE;
      rr_ptr_q  <= '0;
      wdog_q    <= '0;
      tx_data_q <= '0;
      grant_q   <= '0;
      en_q      <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      wdog_q   <= wdog_d;
      en_q     <= (state_d == ARB_START);
      if (capture) begin
        tx_data_q <= req_data[BYTE_W*pick_idx +: BYTE_W];
        grant_q   <= pick_idx;
      end
      if (abort) begin
        err_q <= 1'b1;
      end
    end
  end

  assign tx_en_tx    = en_q;
  assign tx_data     = tx_data_q;
  assign grant_idx   = grant_q;
  assign busy        = (state_q != ARB_IDLE);
  assign err_timeout = err_q;

endmodule

// File: tb/tb_tx_arbiter.sv
// tb_tx_arbiter: directed bench for tx_arbiter with a grant scoreboard and a tbr model.
module tb_tx_arbiter;

  typedef struct {
    logic [1:0] idx;
    logic [7:0] data;
  } grant_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        arb_en;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        tx_en_tx;
  logic [7:0]  tx_data;
  logic        tx_tbr;
  logic [1:0]  grant_idx;
  logic        busy, frame_done, err_timeout;

  logic [3:0]  valid_p, ready_p;
  logic        en_p, busy_p, done_p, err_p;
  logic [7:0]  data_p;
  logic [1:0]  gidx_p;

  logic [7:0]  bytes [4];
  grant_t      sb [$];
  int          checks = 0;
  int          failures = 0;
  int          frame_len = 1;
  bit          stuck = 1'b0;
  int          tcnt;

  always #5 clk = ~clk;

  tx_arbiter #(.NUM_REQ(4), .IDX_W(2), .TIMEOUT(16'd20), .PRIO0(1'b0)) dut (
    .clk(clk), .rst(rst), .arb_en(arb_en), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .tx_en_tx(tx_en_tx), .tx_data(tx_data), .tx_tbr(tx_tbr),
    .grant_idx(grant_idx), .busy(busy), .frame_done(frame_done), .err_timeout(err_timeout)
  );

  tx_arbiter #(.NUM_REQ(4), .IDX_W(2), .TIMEOUT(16'd20), .PRIO0(1'b1)) dut_p (
    .clk(clk), .rst(rst), .arb_en(1'b1), .req_valid(valid_p), .req_data(req_data),
    .req_ready(ready_p), .tx_en_tx(en_p), .tx_data(data_p), .tx_tbr(1'b1),
    .grant_idx(gidx_p), .busy(busy_p), .frame_done(done_p), .err_timeout(err_p)
  );

  // Transmitter model: tbr drops for frame_len cycles after each start strobe.
  always @(posedge clk or posedge rst) begin
    if (rst) tcnt <= 0;
    else if (tx_en_tx) tcnt <= frame_len;
    else if (tcnt != 0) tcnt <= tcnt - 1;
  end
  assign tx_tbr = (tcnt == 0) && !stuck;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input bit on_p, input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(on_p ? done_p : frame_done) && n < 50);
    check(tag, 32'(on_p ? done_p : frame_done), 32'd1);
  endtask

  // Scoreboard monitor plus per-cycle ready invariants.
  always @(negedge clk) begin
    if (!rst) begin
      check("ready_onehot0", 32'($onehot0(req_ready)), 32'd1);
      if (busy) check("ready_zero_busy", 32'(req_ready), 32'd0);
      if (tx_en_tx) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $error("FAIL sb_underflow observed=en_tx expected=no_grant");
        end else begin
          grant_t g;
          g = sb.pop_front();
          check("sb_grant_idx", 32'(grant_idx), 32'(g.idx));
          check("sb_tx_data", 32'(tx_data), 32'(g.data));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int cyc;
    int nframes;
    bytes = '{8'hC3, 8'h5A, 8'hA5, 8'h7E};
    rst = 1'b1; arb_en = 1'b1; req_valid = '0; valid_p = '0;
    req_data = {bytes[3], bytes[2], bytes[1], bytes[0]};
    repeat (2) @(negedge clk);
    check("rst_en", 32'(tx_en_tx), 32'd0);
    check("rst_data", 32'(tx_data), 32'd0);
    check("rst_grant", 32'(grant_idx), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(frame_done), 32'd0);
    check("rst_err", 32'(err_timeout), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd0);
    rst = 1'b0;

    // Single request, earliest frame_done at N+3.
    @(negedge clk); req_valid = 4'b0100; sb.push_back('{2'd2, bytes[2]}); #1;
    check("t1_ready", 32'(req_ready), 32'h4);
    check("t1_busy0", 32'(busy), 32'd0);
    @(negedge clk); req_valid = '0;
    check("t1_en", 32'(tx_en_tx), 32'd1);
    check("t1_data", 32'(tx_data), 32'hA5);
    check("t1_busy", 32'(busy), 32'd1);
    @(negedge clk);
    check("t1_en_strobe", 32'(tx_en_tx), 32'd0);
    check("t1_no_done_w1", 32'(frame_done), 32'd0);
    @(negedge clk);
    check("t1_done", 32'(frame_done), 32'd1);
    @(negedge clk);
    check("t1_idle", 32'(busy), 32'd0);
    check("t1_done_pulse", 32'(frame_done), 32'd0);
    check("t1_hold", 32'(tx_data), 32'hA5);

    // Reset in WAIT: rr_ptr is 3 here, so requester 3 is granted first.
    frame_len = 6;
    @(negedge clk); req_valid = 4'hF; sb.push_back('{2'd3, bytes[3]}); #1;
    check("t5_ready", 32'(req_ready), 32'h8);
    @(negedge clk); req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    check("t5_in_wait", 32'(busy), 32'd1);
    rst = 1'b1; #1;
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_data", 32'(tx_data), 32'd0);
    check("t5_grant", 32'(grant_idx), 32'd0);
    check("t5_en", 32'(tx_en_tx), 32'd0);
    check("t5_done", 32'(frame_done), 32'd0);
    @(negedge clk);
    check("t5_busy_next", 32'(busy), 32'd0);
    rst = 1'b0; frame_len = 2;

    // Fairness from rr_ptr=0: grants 0,1,2,3,0 back-to-back, 5 cycles per frame.
    for (int i = 0; i < 5; i++) sb.push_back('{2'(i % 4), bytes[i % 4]});
    @(negedge clk); req_valid = 4'hF;
    nframes = 0; cyc = 0;
    while (nframes < 5 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (frame_done) nframes++;
    end
    req_valid = '0;
    check("t2_frames", 32'(nframes), 32'd5);
    check("t2_cycles", 32'(cyc), 32'd24);
    check("t2_sb_drained", 32'(sb.size()), 32'd0);

    // arb_en low blocks grants; raising it grants rr_ptr=1; dropping it mid-frame is harmless.
    @(negedge clk); arb_en = 1'b0; req_valid = 4'hF;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("t6_no_ready", 32'(req_ready), 32'd0);
      check("t6_idle", 32'(busy), 32'd0);
      @(negedge clk);
    end
    arb_en = 1'b1; sb.push_back('{2'd1, bytes[1]}); #1;
    check("t6_ready", 32'(req_ready), 32'h2);
    @(negedge clk); req_valid = '0; arb_en = 1'b0;
    wait_done(1'b0, "t6_done_en_low");
    @(negedge clk);
    check("t6_back_idle", 32'(busy), 32'd0);
    arb_en = 1'b1;

    // Watchdog: tbr held low, abort after 20 WAIT cycles with no frame_done.
    @(negedge clk); req_valid = 4'b0001; sb.push_back('{2'd0, bytes[0]}); #1;
    check("t4_ready", 32'(req_ready), 32'h1);
    @(negedge clk); req_valid = '0; stuck = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      check("t4_no_done", 32'(frame_done), 32'd0);
    end
    check("t4_busy_w20", 32'(busy), 32'd1);
    check("t4_err_pre", 32'(err_timeout), 32'd0);
    @(negedge clk);
    check("t4_aborted", 32'(busy), 32'd0);
    check("t4_err", 32'(err_timeout), 32'd1);
    check("t4_no_done_abort", 32'(frame_done), 32'd0);
    stuck = 1'b0;
    repeat (3) @(negedge clk);
    check("t4_err_sticky", 32'(err_timeout), 32'd1);
    rst = 1'b1; #1;
    check("t4_err_cleared", 32'(err_timeout), 32'd0);
    @(negedge clk); rst = 1'b0;

    // PRIO0 instance: move rr_ptr to 3, then requester 0 must still win over 3.
    @(negedge clk); valid_p = 4'b0100; #1;
    check("t3_ready_a", 32'(ready_p), 32'h4);
    @(negedge clk); valid_p = '0;
    check("t3_grant_a", 32'(gidx_p), 32'd2);
    wait_done(1'b1, "t3_done_a");
    @(negedge clk); valid_p = 4'b1001; #1;
    check("t3_ready_prio", 32'(ready_p), 32'h1);
    @(negedge clk); valid_p = 4'b1000;
    check("t3_grant_prio", 32'(gidx_p), 32'd0);
    check("t3_en_prio", 32'(en_p), 32'd1);
    check("t3_data_prio", 32'(data_p), 32'(bytes[0]));
    wait_done(1'b1, "t3_done_b");
    @(negedge clk); #1;
    check("t3_ready_3", 32'(ready_p), 32'h8);
    @(negedge clk); valid_p = '0;
    check("t3_grant_3", 32'(gidx_p), 32'd3);

    check("sb_empty_end", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
